// File: rtl/exu_dec_stage_if.sv
// Handshake/payload bundle between the IFU side, the decode stage and the EXU consumer.
// Latency: none, this is only wiring.
// Backpressure: carries i_valid/i_ready upstream and o_valid/o_ready downstream.
interface exu_dec_stage_if #(
  parameter int XLEN        = 32,
  parameter int PC_SIZE     = 32,
  parameter int RFIDX_WIDTH = 5
);
  // Instruction side
  logic                   i_valid;
  logic                   i_ready;
  logic [31:0]            i_instr;
  logic [PC_SIZE-1:0]     i_pc;
  logic                   i_prdt_taken;
  logic                   i_flush;
  logic                   i_resume;
  // Decoded entry side
  logic                   o_valid;
  logic                   o_ready;
  logic [2:0]             o_grp;
  logic [4:0]             o_op;
  logic [RFIDX_WIDTH-1:0] o_rs1idx;
  logic [RFIDX_WIDTH-1:0] o_rs2idx;
  logic [RFIDX_WIDTH-1:0] o_rdidx;
  logic                   o_rs1en;
  logic                   o_rs2en;
  logic                   o_rdwen;
  logic                   o_op2imm;
  logic                   o_op1pc;
  logic [XLEN-1:0]        o_imm;
  logic [PC_SIZE-1:0]     o_pc;
  logic                   o_prdt_taken;
  logic                   o_illegal;
  logic                   o_halted;
  logic [31:0]            o_dec_cnt;

  // Environment: feeds instructions and consumes decoded entries
  modport master (
    output i_valid, i_instr, i_pc, i_prdt_taken, i_flush, i_resume, o_ready,
    input  i_ready, o_valid, o_grp, o_op, o_rs1idx, o_rs2idx, o_rdidx,
           o_rs1en, o_rs2en, o_rdwen, o_op2imm, o_op1pc, o_imm, o_pc,
           o_prdt_taken, o_illegal, o_halted, o_dec_cnt
  );

  // Decode stage
  modport slave (
    input  i_valid, i_instr, i_pc, i_prdt_taken, i_flush, i_resume, o_ready,
    output i_ready, o_valid, o_grp, o_op, o_rs1idx, o_rs2idx, o_rdidx,
           o_rs1en, o_rs2en, o_rdwen, o_op2imm, o_op1pc, o_imm, o_pc,
           o_prdt_taken, o_illegal, o_halted, o_dec_cnt
  );
endinterface

// File: rtl/exu_dec_stage.sv
// RV32I(+M) decoder feeding a 2-entry elastic output buffer, with an EBREAK/illegal halt FSM.
// Latency: 1 cycle, an instruction accepted at edge N is presented after edge N.
// Backpressure: i_ready depends only on registered count/state and i_flush; a full buffer refuses pushes even while popping.
module exu_dec_stage #(
  parameter int XLEN        = 32,
  parameter int PC_SIZE     = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int HAS_M       = 0
) (
  input  logic           clk,
  input  logic           rst,
  exu_dec_stage_if.slave bus
);

  localparam logic [2:0] GRP_ALU = 3'd0;
  localparam logic [2:0] GRP_BJP = 3'd1;
  localparam logic [2:0] GRP_LSU = 3'd2;
  localparam logic [2:0] GRP_MD  = 3'd3;
  localparam logic [2:0] GRP_SYS = 3'd4;

  localparam logic [4:0] SYS_EBREAK  = 5'd1;
  localparam logic [4:0] SYS_ILLEGAL = 5'd2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef struct packed {
    logic [2:0]             grp;
    logic [4:0]             op;
    logic [RFIDX_WIDTH-1:0] rs1idx;
    logic [RFIDX_WIDTH-1:0] rs2idx;
    logic [RFIDX_WIDTH-1:0] rdidx;
    logic                   rs1en;
    logic                   rs2en;
    logic                   rdwen;
    logic                   op2imm;
    logic                   op1pc;
    logic [XLEN-1:0]        imm;
    logic [PC_SIZE-1:0]     pc;
    logic                   prdt_taken;
    logic                   illegal;
  } ent_t;

  // Instruction fields
  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr = bus.i_instr;
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [2:0]  grp;
  logic [4:0]  op;
  logic        use_rs1, use_rs2, use_rd, op2imm, op1pc, ill;
  logic [31:0] imm32;

  // Raw decode: group/op, which register fields are meaningful, immediate format
  always_comb begin
    grp     = GRP_ALU;
    op      = 5'd0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    op2imm  = 1'b0;
    op1pc   = 1'b0;
    imm32   = 32'd0;
    ill     = 1'b0;
    if (opc[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opc[6:2])
        5'b01101: begin // LUI
          op = 5'd10; use_rd = 1'b1; op2imm = 1'b1; imm32 = imm_u;
        end
        5'b00101: begin // AUIPC
          op = 5'd11; use_rd = 1'b1; op2imm = 1'b1; op1pc = 1'b1; imm32 = imm_u;
        end
        5'b11011: begin // JAL
          grp = GRP_BJP; op = 5'd0; use_rd = 1'b1; op2imm = 1'b1; op1pc = 1'b1; imm32 = imm_j;
        end
        5'b11001: begin // JALR
          grp = GRP_BJP; op = 5'd1; use_rs1 = 1'b1; use_rd = 1'b1; op2imm = 1'b1; imm32 = imm_i;
          ill = (f3 != 3'b000);
        end
        5'b11000: begin // BRANCH
          grp = GRP_BJP; use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_b;
          case (f3)
            3'b000:  op = 5'd2;
            3'b001:  op = 5'd3;
            3'b100:  op = 5'd4;
            3'b101:  op = 5'd5;
            3'b110:  op = 5'd6;
            3'b111:  op = 5'd7;
            default: ill = 1'b1;
          endcase
        end
        5'b00000: begin // LOAD
          grp = GRP_LSU; use_rs1 = 1'b1; use_rd = 1'b1; op2imm = 1'b1; imm32 = imm_i;
          case (f3)
            3'b000:  op = 5'd0;
            3'b001:  op = 5'd1;
            3'b010:  op = 5'd2;
            3'b100:  op = 5'd3;
            3'b101:  op = 5'd4;
            default: ill = 1'b1;
          endcase
        end
        5'b01000: begin // STORE
          grp = GRP_LSU; use_rs1 = 1'b1; use_rs2 = 1'b1; op2imm = 1'b1; imm32 = imm_s;
          case (f3)
            3'b000:  op = 5'd5;
            3'b001:  op = 5'd6;
            3'b010:  op = 5'd7;
            default: ill = 1'b1;
          endcase
        end
        5'b00100: begin // OP-IMM
          use_rs1 = 1'b1; use_rd = 1'b1; op2imm = 1'b1; imm32 = imm_i;
          case (f3)
            3'b000:  op = (instr == 32'h0000_0013) ? 5'd12 : 5'd0;
            3'b001:  begin op = 5'd2; ill = (f7 != 7'b0000000); end
            3'b010:  op = 5'd3;
            3'b011:  op = 5'd4;
            3'b100:  op = 5'd5;
            3'b101: begin
              if (f7 == 7'b0000000)      op = 5'd6;
              else if (f7 == 7'b0100000) op = 5'd7;
              else                       ill = 1'b1;
            end
            3'b110:  op = 5'd8;
            default: op = 5'd9;
          endcase
        end
        5'b01100: begin // OP (register-register), R-type carries no immediate
          use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
          if (f7 == 7'b0000000) begin
            case (f3)
              3'b000:  op = 5'd0;
              3'b001:  op = 5'd2;
              3'b010:  op = 5'd3;
              3'b011:  op = 5'd4;
              3'b100:  op = 5'd5;
              3'b101:  op = 5'd6;
              3'b110:  op = 5'd8;
              default: op = 5'd9;
            endcase
          end else if (f7 == 7'b0100000) begin
            if (f3 == 3'b000)      op = 5'd1;
            else if (f3 == 3'b101) op = 5'd7;
            else                   ill = 1'b1;
          end else if ((f7 == 7'b0000001) && (HAS_M != 0)) begin
            grp = GRP_MD; op = {2'b00, f3};
          end else begin
            ill = 1'b1;
          end
        end
        5'b00011: begin // MISC-MEM
          grp = GRP_SYS; op = 5'd3; ill = (f3 != 3'b000);
        end
        5'b11100: begin // SYSTEM, only ECALL/EBREAK are supported
          grp = GRP_SYS;
          if (instr == 32'h0000_0073)      op = 5'd0;
          else if (instr == 32'h0010_0073) op = SYS_EBREAK;
          else                             ill = 1'b1;
        end
        default: ill = 1'b1;
      endcase
    end
  end

  logic rv32e_bad, ill_all, dec_halt;
  ent_t dec;

  // Final decoded entry: RV32E index check, illegal override, x0 suppression of enables
  always_comb begin
    rv32e_bad = (RFIDX_WIDTH == 4) &&
                ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]));
    ill_all        = ill || rv32e_bad;
    dec            = '0;
    dec.rs1idx     = rs1[RFIDX_WIDTH-1:0];
    dec.rs2idx     = rs2[RFIDX_WIDTH-1:0];
    dec.rdidx      = rd[RFIDX_WIDTH-1:0];
    dec.pc         = bus.i_pc;
    dec.prdt_taken = bus.i_prdt_taken;
    if (ill_all) begin
      dec.grp     = GRP_SYS;
      dec.op      = SYS_ILLEGAL;
      dec.illegal = 1'b1;
    end else begin
      dec.grp    = grp;
      dec.op     = op;
      dec.rs1en  = use_rs1 && (rs1 != 5'd0);
      dec.rs2en  = use_rs2 && (rs2 != 5'd0);
      dec.rdwen  = use_rd && (rd != 5'd0);
      dec.op2imm = op2imm;
      dec.op1pc  = op1pc;
      dec.imm    = XLEN'($signed(imm32));
    end
    dec_halt = (dec.grp == GRP_SYS) && ((dec.op == SYS_EBREAK) || (dec.op == SYS_ILLEGAL));
  end

  ent_t        ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [0:0]  state_q, state_d;
  logic [31:0] dec_cnt_q, dec_cnt_d;
  logic        push, pop;

  assign bus.i_ready = (cnt_q < 2'd2) && (state_q == ST_RUN) && !bus.i_flush;
  assign bus.o_valid = (cnt_q != 2'd0);
  assign push        = bus.i_valid && bus.i_ready;
  assign pop         = bus.o_valid && bus.o_ready;

  // Buffer occupancy and entry shifting; flush empties it but a same-cycle pop still counts
  always_comb begin
    ent0_d    = ent0_q;
    ent1_d    = ent1_q;
    cnt_d     = cnt_q;
    dec_cnt_d = dec_cnt_q + (pop ? 32'd1 : 32'd0);
    if (bus.i_flush) begin
      cnt_d = 2'd0;
    end else if (push && pop) begin
      ent0_d = dec; // only reachable with one entry held
    end else if (pop) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 2'd1;
    end else if (push) begin
      if (cnt_q == 2'd0) ent0_d = dec;
      else               ent1_d = dec;
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Halt FSM: an accepted EBREAK/illegal stops intake; resume or flush restarts it
  always_comb begin
    state_d = state_q;
    if (bus.i_flush)                          state_d = ST_RUN;
    else if (state_q == ST_HALT) begin
      if (bus.i_resume)                       state_d = ST_RUN;
    end else if (push && dec_halt)            state_d = ST_HALT;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q    <= '0;
      ent1_q    <= '0;
      cnt_q     <= 2'd0;
      state_q   <= ST_RUN;
      dec_cnt_q <= 32'd0;
    end else begin
      ent0_q    <= ent0_d;
      ent1_q    <= ent1_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      dec_cnt_q <= dec_cnt_d;
    end
  end

  assign bus.o_grp        = ent0_q.grp;
  assign bus.o_op         = ent0_q.op;
  assign bus.o_rs1idx     = ent0_q.rs1idx;
  assign bus.o_rs2idx     = ent0_q.rs2idx;
  assign bus.o_rdidx      = ent0_q.rdidx;
  assign bus.o_rs1en      = ent0_q.rs1en;
  assign bus.o_rs2en      = ent0_q.rs2en;
  assign bus.o_rdwen      = ent0_q.rdwen;
  assign bus.o_op2imm     = ent0_q.op2imm;
  assign bus.o_op1pc      = ent0_q.op1pc;
  assign bus.o_imm        = ent0_q.imm;
  assign bus.o_pc         = ent0_q.pc;
  assign bus.o_prdt_taken = ent0_q.prdt_taken;
  assign bus.o_illegal    = ent0_q.illegal;
  assign bus.o_halted     = (state_q == ST_HALT);
  assign bus.o_dec_cnt    = dec_cnt_q;

endmodule
